// File: rtl/ddr_in_burst_capture.sv
// DDR input capture for the SDRAM read path.
// Samples datain on both edges of inclock, captures fixed-length read bursts after a
// CAS latency and buffers rising/falling sample pairs in a first-word-fall-through FIFO.
// Optional feature macro: DDR_IN_RESYNC_EN adds one posedge register ahead of the FIFO push.
module ddr_in_burst_capture #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned CAS_LAT    = 2,
  parameter int unsigned BURST_MAX  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             inclock,
  input  logic             sclr,
  input  logic             inclocken,
  input  logic [WIDTH-1:0] datain,
  input  logic             start,
  input  logic [3:0]       burst_len,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataout_h,
  output logic [WIDTH-1:0] dataout_l,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned DW = 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StWait, StCapt} state_t;

  state_t           state_q;
  logic [2:0]       lat_q;
  logic [3:0]       beats_q;
  logic             busy_q;
  logic             done_q;
  logic [3:0]       len_clamped;

  logic [WIDTH-1:0] cap_h;
  logic [WIDTH-1:0] cap_n;
  logic [DW-1:0]    pair_d;

  logic             capt_push;
  logic             capt_last;
  logic             push;
  logic             push_last;
  logic [DW-1:0]    push_data;

  logic [DW-1:0]    mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    rd_next;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             valid_q;
  logic             ovf_q;
  logic [DW-1:0]    head_q;
  logic             pop;
  logic             full;
  logic             wr_en;

  // Rising-edge sample; held while the capture clock enable is low.
  always_ff @(posedge inclock) begin
    if (inclocken) cap_h <= datain;
  end

  // Falling-edge sample that completes the pair started by the preceding rising edge.
  always_ff @(negedge inclock) begin
    if (inclocken) cap_n <= datain;
  end

  // The pair being realigned at this rising edge: previous posedge sample plus its negedge.
  assign pair_d = {cap_h, cap_n};

  // Zero-length requests become one beat; oversized requests saturate.
  always_comb begin
    len_clamped = burst_len;
    if (burst_len == 4'd0) begin
      len_clamped = 4'd1;
    end else if (burst_len > 4'(BURST_MAX)) begin
      len_clamped = 4'(BURST_MAX);
    end
  end

  assign capt_push = (state_q == StCapt) && inclocken;
  assign capt_last = capt_push && (beats_q == 4'd1);

`ifdef DDR_IN_RESYNC_EN
  logic [DW-1:0] pair_q;
  logic          push_q;
  logic          last_q;

  // Extra retiming stage; it advances only on enabled edges so no beat is lost or repeated.
  always_ff @(posedge inclock) begin
    if (sclr) begin
      pair_q <= '0;
      push_q <= 1'b0;
      last_q <= 1'b0;
    end else if (inclocken) begin
      pair_q <= pair_d;
      push_q <= capt_push;
      last_q <= capt_last;
    end
  end

  assign push      = push_q && inclocken;
  assign push_last = last_q && inclocken;
  assign push_data = pair_q;
`else
  assign push      = capt_push;
  assign push_last = capt_last;
  assign push_data = pair_d;
`endif

  // Burst control FSM: IDLE -> WAIT (CAS latency) -> CAPT (one beat per enabled edge).
  always_ff @(posedge inclock) begin
    if (sclr) begin
      state_q <= StIdle;
      lat_q   <= '0;
      beats_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // done is a single-cycle pulse regardless of the clock enable.
      done_q <= push_last;
      if (inclocken) begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              state_q <= StWait;
              busy_q  <= 1'b1;
              lat_q   <= 3'(CAS_LAT);
              beats_q <= len_clamped;
            end
          end
          StWait: begin
            if (lat_q == 3'd1) begin
              state_q <= StCapt;
            end else begin
              lat_q <= lat_q - 3'd1;
            end
          end
          StCapt: begin
            beats_q <= beats_q - 4'd1;
            if (beats_q == 4'd1) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign pop     = valid_q && out_ready;
  assign full    = (count_q == CW'(FIFO_DEPTH));
  // A push into a full FIFO still lands if the head leaves on the same edge.
  assign wr_en   = push && (!full || pop);
  assign rd_next = rd_ptr_q + 1'b1;
  assign count_d = count_q + CW'(wr_en) - CW'(pop);

  // FIFO storage; contents need no reset since count/valid gate visibility.
  always_ff @(posedge inclock) begin
    if (!sclr && wr_en) mem[wr_ptr_q] <= push_data;
  end

  // FIFO pointers, occupancy, sticky overflow and registered fall-through head.
  always_ff @(posedge inclock) begin
    if (sclr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      head_q   <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_next;
      count_q <= count_d;
      valid_q <= (count_d != '0);
      if (push && full && !pop) ovf_q <= 1'b1;
      if (pop && (count_q > CW'(1))) begin
        head_q <= mem[rd_next];
      end else if (wr_en && ((count_q == '0) || pop)) begin
        // Empty, or the only entry is leaving: the incoming pair becomes the head.
        head_q <= push_data;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = valid_q;
  assign overflow  = ovf_q;
  assign dataout_h = head_q[DW-1:WIDTH];
  assign dataout_l = head_q[WIDTH-1:0];

endmodule
